// File: rtl/mul_addtree_2_stage.sv
`default_nettype none
// ============================================================================
// Module      : mul_addtree_2_stage
// Description : Unsigned WIDTH x WIDTH multiplier built as a shift-and-add
//               tree. It has two register stages and a throughput of one
//               operand pair per clock. The fixed latency is 2 edges. There
//               is no handshake, so the consumer counts cycles.
// Ports       : clk  - clock; all state updates on the rising edge
//               clr  - synchronous active-high clear of every register
//               x    - multiplicand, unsigned, WIDTH bits
//               y    - multiplier, unsigned, WIDTH bits
//               out  - registered product x*y, unsigned, 2*WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module mul_addtree_2_stage #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] out
);

  localparam int c_PW   = 2 * WIDTH;
  localparam int c_HALF = WIDTH / 2;

  // Partial products. Each one is zero-extended to full product width
  // before the shift, so no bits are lost.
  logic [c_PW-1:0] w_pp [WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign w_pp[gi] = y[gi] ? ({{WIDTH{1'b0}}, x} << gi) : '0;
    end
  endgenerate

  // Stage-1 next state: the lower and upper halves of the tree are summed
  // separately. The full-width accumulators cannot overflow, because every
  // partial sum is bounded by the full product.
  logic [c_PW-1:0] s_lo_d, s_hi_d;

  always_comb begin
    s_lo_d = '0;
    s_hi_d = '0;
    for (int i = 0; i < c_HALF; i++) begin
      s_lo_d = s_lo_d + w_pp[i];
    end
    for (int i = c_HALF; i < WIDTH; i++) begin
      s_hi_d = s_hi_d + w_pp[i];
    end
  end

  logic [c_PW-1:0] s_lo_q, s_hi_q;
  logic [c_PW-1:0] out_d, out_q;

  // Stage-2 next state: combine the two half-trees.
  assign out_d = s_lo_q + s_hi_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      s_lo_q <= '0;
      s_hi_q <= '0;
      out_q  <= '0;
    end else begin
      s_lo_q <= s_lo_d;
      s_hi_q <= s_hi_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_addtree_2_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_addtree_2_stage
// Description : Scoreboard bench for mul_addtree_2_stage. The driver pushes
//               the product expected for each issued operand pair. A monitor
//               pops the entries and compares them with out after the edge
//               at which each product is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_addtree_2_stage;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;

  logic             clk;
  logic             clr;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [PW-1:0]    out;

  mul_addtree_2_stage #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .x   (x),
    .y   (y),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;   // edge number after which out must hold val
    logic [PW-1:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;

  // Inputs are applied on the falling edge and sampled at the next rising
  // edge (number cyc+1). The product is visible after the edge that follows
  // (cyc+2). A clear at the issue edge kills the product.
  task automatic drive(input bit cl, input int a, input int b);
    exp_t e;
    @(negedge clk);
    clr = cl;
    x   = WIDTH'(a);
    y   = WIDTH'(b);
    e.due = cyc + 2;
    e.val = cl ? '0 : PW'(a * b);
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t          e;
    logic [PW-1:0] expv;
    bit            clr_s;
    forever begin
      @(posedge clk);
      cyc++;
      clr_s = clr;
      #1;
      if (clr_s) armed = 1'b1;
      if (armed) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          // A clear at this very edge overrides whatever was in flight.
          expv = clr_s ? '0 : e.val;
          checks++;
          if (out !== expv) begin
            errors++;
            $display("FAIL product edge=%0d got=%0d expected=%0d", cyc, out, expv);
          end
        end else if (clr_s) begin
          checks++;
          if (out !== '0) begin
            errors++;
            $display("FAIL reset_out edge=%0d got=%0d expected=0", cyc, out);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    x   = 4'd9;
    y   = 4'd7;
    // 1. Reset held for two edges with non-zero operands.
    drive(1, 9, 7);
    drive(1, 9, 7);
    // 2. Basic latency, with operands held.
    drive(0, 5, 5);
    drive(0, 5, 5);
    // 3. Corner cases.
    drive(0, 15, 15);
    drive(0, 0, 9);
    drive(0, 1, 15);
    drive(0, 8, 8);
    // 4. Streaming.
    drive(0, 6, 6);
    drive(0, 7, 7);
    drive(0, 8, 8);
    drive(0, 3, 12);
    // 5. Mid-stream reset, then resume.
    drive(0, 10, 11);
    drive(0, 12, 13);
    drive(1, 14, 14);
    drive(0, 2, 3);
    drive(0, 4, 9);
    // 6. Exhaustive back-to-back.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drive(0, a, b);
    // Random operands with occasional clears.
    for (int n = 0; n < 300; n++)
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 15), $urandom_range(0, 15));
    // Drain the pipeline.
    for (int n = 0; n < 3; n++)
      drive(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    // The three drain entries are still in flight after the last drive.
    // Only entries that are already overdue count as missed.
    if (q.size() > 0 && q[0].due <= cyc) begin
      errors++;
      $display("FAIL drain pending=%0d got_due=%0d required_after=%0d", q.size(), q[0].due, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
